avalon_burst_ram: RTL

Avalon-MM burst-capable slave memory that answers the cache's bus master port: single-word and burst reads/writes from the cache line-fill and write-back engine. Backed by an internal word array with programmable read latency, back-to-back burst read beats, and `waitRequest` back-pressure while a read burst is in flight. Serves as on-chip main memory in the SoC and as the memory responder in cache benches.

---
 rtl/avalon_burst_ram.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/avalon_burst_ram.sv
// avalon_burst_ram: Avalon-MM burst slave backed by an on-chip word array.
// Single and burst writes go in with zero wait states. Reads wait a
// programmable latency, then return one beat per cycle with no gaps.
// waitRequest stays high while a read is in flight.

module avalon_burst_ram #(
  parameter int SIZE              = 64 * 1024,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int READ_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic [31:0]                  s0_address,
  input  logic [3:0]                   s0_byteEnable,
  input  logic                         s0_read,
  input  logic                         s0_write,
  input  logic [31:0]                  s0_writeData,
  output logic                         s0_waitRequest,
  input  logic                         s0_beginBurstTransfer,
  input  logic [BURST_COUNT_WIDTH-1:0] s0_burstCount,
  output logic [31:0]                  s0_readData,
  output logic                         s0_readDataValid
);

  localparam int DEPTH = SIZE / 4;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [BURST_COUNT_WIDTH-1:0] COUNT_ONE = BURST_COUNT_WIDTH'(1);
  localparam logic [AW-1:0]                ADDR_ONE  = AW'(1);
  localparam logic [3:0]                   LAT_LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [AW-1:0]                addr;
  logic [AW-1:0]                addr_next;
  logic [BURST_COUNT_WIDTH-1:0] remain;
  logic [BURST_COUNT_WIDTH-1:0] remain_next;
  logic [3:0]                   lat;
  logic [3:0]                   lat_next;

  logic                         mem_we;
  logic [AW-1:0]                mem_idx;
  logic                         beat_issue;
  logic [AW-1:0]                req_idx;
  logic [BURST_COUNT_WIDTH-1:0] eff_count;

  logic [31:0] mem [DEPTH];

  // The first-beat marker and the out-of-range address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s0_address[31:AW+2], s0_address[1:0], s0_beginBurstTransfer};

  assign req_idx   = s0_address[AW+1:2];
  assign eff_count = (s0_burstCount == '0) ? COUNT_ONE : s0_burstCount;

  assign s0_waitRequest = (state == RD_WAIT) || (state == RD_DATA);

  // State register; reset drops any burst in progress back to IDLE.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, burst bookkeeping and memory write strobe.
  always_comb begin
    state_next  = state;
    addr_next   = addr;
    remain_next = remain;
    lat_next    = lat;
    mem_we      = 1'b0;
    mem_idx     = addr;
    beat_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (s0_write) begin
          mem_we  = 1'b1;
          mem_idx = req_idx;
          if (eff_count > COUNT_ONE) begin
            addr_next   = req_idx + ADDR_ONE;
            remain_next = eff_count - COUNT_ONE;
            state_next  = WR_BURST;
          end
        end else if (s0_read) begin
          addr_next   = req_idx;
          remain_next = eff_count;
          lat_next    = LAT_LOAD;
          state_next  = (READ_LATENCY == 1) ? RD_DATA : RD_WAIT;
        end
      end
      WR_BURST: begin
        if (s0_write) begin
          mem_we      = 1'b1;
          addr_next   = addr + ADDR_ONE;
          remain_next = remain - COUNT_ONE;
          if (remain <= COUNT_ONE) begin
            state_next = IDLE;
          end
        end
      end
      RD_WAIT: begin
        lat_next = lat - 4'd1;
        if (lat <= 4'd1) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        beat_issue  = 1'b1;
        addr_next   = addr + ADDR_ONE;
        remain_next = remain - COUNT_ONE;
        if (remain <= COUNT_ONE) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst counters and the registered read beat.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      addr             <= '0;
      remain           <= '0;
      lat              <= '0;
      s0_readData      <= '0;
      s0_readDataValid <= 1'b0;
    end else begin
      addr             <= addr_next;
      remain           <= remain_next;
      lat              <= lat_next;
      s0_readDataValid <= beat_issue;
      if (beat_issue) begin
        s0_readData <= mem[addr];
      end
    end
  end

  // Byte-masked write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s0_byteEnable[i]) begin
          mem[mem_idx][8*i +: 8] <= s0_writeData[8*i +: 8];
        end
      end
    end
  end

endmodule
